// File: rtl/vending_machine_multi.sv
// Multi-product vending machine: coin credit accumulation, per-product stock,
// single-cycle vend pulse and coin-by-coin change return.
module vending_machine_multi #(
  parameter int                          NPROD      = 4,
  parameter int                          CREDIT_W   = 6,
  parameter logic [NPROD*CREDIT_W-1:0]   PRICES     = {6'd25, 6'd20, 6'd15, 6'd10},
  parameter int                          MAX_CREDIT = 35,
  parameter int                          STOCK_W    = 4,
  parameter int                          STOCK_INIT = 3,
  localparam int                         SELW       = (NPROD > 1) ? $clog2(NPROD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic [SELW-1:0]     sel,
  input  logic                buy,
  input  logic                cancel,
  output logic                vend,
  output logic [SELW-1:0]     vend_id,
  output logic                change_five,
  output logic                coin_reject,
  output logic [NPROD-1:0]    sold_out,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t                r_state;
  logic [CREDIT_W-1:0]   r_credit;
  logic                  r_vend;
  logic [SELW-1:0]       r_vend_id;
  logic                  r_coin_reject;
  logic                  r_busy;
  logic [NPROD-1:0]      r_sold_out;
  logic [STOCK_W-1:0]    r_stock [NPROD];

  state_t                w_state_nx;
  logic [CREDIT_W-1:0]   w_credit_nx;
  logic                  w_vend_nx;
  logic [SELW-1:0]       w_vend_id_nx;
  logic                  w_reject_nx;
  logic [NPROD-1:0]      w_dec;
  logic [NPROD-1:0]      w_sel_mask;
  logic [CREDIT_W-1:0]   w_price;
  logic                  w_stock_avail;
  logic                  w_sel_ok;
  logic                  w_buy_ok;
  logic                  w_coin_valid;
  logic [CREDIT_W-1:0]   w_coin_val;
  logic [CREDIT_W:0]     w_coin_sum;
  logic                  w_coin_fits;

  // Decode the selected product; an out-of-range select matches nothing.
  always_comb begin
    w_price       = '0;
    w_stock_avail = 1'b0;
    w_sel_ok      = 1'b0;
    w_sel_mask    = '0;
    for (int i = 0; i < NPROD; i++) begin
      if (sel == SELW'(i)) begin
        w_sel_ok      = 1'b1;
        w_sel_mask[i] = 1'b1;
        w_price       = PRICES[i*CREDIT_W +: CREDIT_W];
        w_stock_avail = (r_stock[i] != '0);
      end
    end
  end

  always_comb begin
    w_coin_val = '0;
    case (coin)
      2'b01:   w_coin_val = CREDIT_W'(5);
      2'b11:   w_coin_val = CREDIT_W'(10);
      default: w_coin_val = '0;
    endcase
  end

  assign w_coin_valid = coin[0];
  assign w_coin_sum   = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_coin_fits  = (w_coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign w_buy_ok     = buy && (r_state == S_CREDIT) && w_sel_ok && w_stock_avail &&
                        (r_credit >= w_price);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Priority inside IDLE/CREDIT: cancel, then buy, then coin.
  always_comb begin
    w_state_nx   = r_state;
    w_credit_nx  = r_credit;
    w_vend_nx    = 1'b0;
    w_vend_id_nx = '0;
    w_reject_nx  = 1'b0;
    w_dec        = '0;
    case (r_state)
      S_IDLE, S_CREDIT: begin
        if (cancel && (r_state == S_CREDIT)) begin
          w_state_nx  = S_CHANGE;
          w_reject_nx = (coin != 2'b00);
        end else if (w_buy_ok) begin
          w_state_nx   = S_VEND;
          w_vend_nx    = 1'b1;
          w_vend_id_nx = sel;
          w_credit_nx  = r_credit - w_price;
          w_dec        = w_sel_mask;
          w_reject_nx  = (coin != 2'b00);
        end else if (w_coin_valid && w_coin_fits) begin
          w_credit_nx = w_coin_sum[CREDIT_W-1:0];
          w_state_nx  = S_CREDIT;
        end else begin
          w_reject_nx = (coin != 2'b00);
        end
      end
      S_VEND: begin
        w_state_nx  = (r_credit != '0) ? S_CHANGE : S_IDLE;
        w_reject_nx = (coin != 2'b00);
      end
      S_CHANGE: begin
        w_reject_nx = (coin != 2'b00);
        if (r_credit <= CREDIT_W'(5)) begin
          w_credit_nx = '0;
          w_state_nx  = S_IDLE;
        end else begin
          w_credit_nx = r_credit - CREDIT_W'(5);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit      <= '0;
      r_vend        <= 1'b0;
      r_vend_id     <= '0;
      r_coin_reject <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_credit      <= w_credit_nx;
      r_vend        <= w_vend_nx;
      r_vend_id     <= w_vend_id_nx;
      r_coin_reject <= w_reject_nx;
      r_busy        <= (w_state_nx == S_VEND) || (w_state_nx == S_CHANGE);
    end
  end

  // Sold-out flags are registered alongside the decrement that empties a slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPROD; i++) begin
      if (rst) begin
        r_stock[i]    <= STOCK_W'(STOCK_INIT);
        r_sold_out[i] <= 1'b0;
      end else if (w_dec[i]) begin
        r_stock[i]    <= r_stock[i] - STOCK_W'(1);
        r_sold_out[i] <= (r_stock[i] == STOCK_W'(1));
      end
    end
  end

  assign vend        = r_vend;
  assign vend_id     = r_vend_id;
  assign change_five = (r_state == S_CHANGE);
  assign coin_reject = r_coin_reject;
  assign sold_out    = r_sold_out;
  assign credit      = r_credit;
  assign busy        = r_busy;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed vector table, hand sequences and
// random traffic against a queue-based output-schedule reference model.
module tb_vending_machine_multi;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic [1:0] sel;
  logic       buy;
  logic       cancel;
  logic       vend;
  logic [1:0] vend_id;
  logic       change_five;
  logic       coin_reject;
  logic [3:0] sold_out;
  logic [5:0] credit;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  vending_machine_multi dut (
    .clk(clk), .rst(rst), .coin(coin), .sel(sel), .buy(buy), .cancel(cancel),
    .vend(vend), .vend_id(vend_id), .change_five(change_five),
    .coin_reject(coin_reject), .sold_out(sold_out), .credit(credit), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: credit and stock as integers; everything the machine will
  // emit after a purchase or refund is queued one entry per output cycle.
  typedef struct {bit v; int id; bit c;} ent_t;
  ent_t sched[$];
  int   mdl_credit;
  int   mdl_stock[4];
  bit   mdl_rej;
  int   PRICE[4] = '{10, 15, 20, 25};
  localparam int MAXC = 35;

  task automatic schedule_refund();
    ent_t e;
    e.v = 1'b0; e.id = 0; e.c = 1'b1;
    for (int k = 0; k < mdl_credit / 5; k++) sched.push_back(e);
  endtask

  task automatic model_step();
    ent_t e;
    int val;
    if (rst) begin
      mdl_credit = 0;
      foreach (mdl_stock[i]) mdl_stock[i] = 3;
      sched.delete();
      mdl_rej = 1'b0;
      return;
    end
    mdl_rej = (coin != 2'b00);
    val = (coin == 2'b01) ? 5 : (coin == 2'b11) ? 10 : 0;
    if (sched.size() > 0) begin
      e = sched.pop_front();
      if (e.c) mdl_credit -= 5;
    end else if (cancel && mdl_credit > 0) begin
      schedule_refund();
    end else if (buy && mdl_stock[sel] > 0 && mdl_credit >= PRICE[sel]) begin
      mdl_credit -= PRICE[sel];
      mdl_stock[sel]--;
      e.v = 1'b1; e.id = int'(sel); e.c = 1'b0;
      sched.push_back(e);
      schedule_refund();
    end else if (val != 0 && mdl_credit + val <= MAXC) begin
      mdl_credit += val;
      mdl_rej = 1'b0;
    end
  endtask

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    int ev, ec, so;
    ev = (sched.size() > 0 && sched[0].v) ? 1 : 0;
    ec = (sched.size() > 0 && sched[0].c) ? 1 : 0;
    so = 0;
    for (int i = 0; i < 4; i++) if (mdl_stock[i] == 0) so |= (1 << i);
    chk("model credit", int'(credit), mdl_credit);
    chk("model vend", int'(vend), ev);
    if (ev == 1) chk("model vend_id", int'(vend_id), sched[0].id);
    chk("model change_five", int'(change_five), ec);
    chk("model coin_reject", int'(coin_reject), int'(mdl_rej));
    chk("model busy", int'(busy), (sched.size() > 0) ? 1 : 0);
    chk("model sold_out", int'(sold_out), so);
  endtask

  task automatic tick(logic r, logic [1:0] c, logic [1:0] s, logic b, logic x);
    rst = r; coin = c; sel = s; buy = b; cancel = x;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic       r;  logic [1:0] c;  logic [1:0] s;  logic b;  logic x;
    logic       v;  logic [1:0] id; logic ch;       logic rj;
    logic [5:0] cr; logic bz;       logic [3:0] so;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(logic r, logic [1:0] c, logic [1:0] s, logic b, logic x,
                              logic v, logic [1:0] id, logic ch, logic rj, int cr,
                              logic bz, logic [3:0] so);
    vec_t t;
    t.r = r; t.c = c; t.s = s; t.b = b; t.x = x;
    t.v = v; t.id = id; t.ch = ch; t.rj = rj; t.cr = 6'(cr); t.bz = bz; t.so = so;
    return t;
  endfunction

  initial begin
    rst = 1'b1; coin = 2'b00; sel = 2'b00; buy = 1'b0; cancel = 1'b0;
    // rst coin sel buy cancel | vend id chg rej credit busy sold
    vt.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0));
    // exact payment for product 1 (price 15)
    vt.push_back(mk(0,1,0,0,0, 0,0,0,0, 5,0,0));
    vt.push_back(mk(0,1,0,0,0, 0,0,0,0,10,0,0));
    vt.push_back(mk(0,1,0,0,0, 0,0,0,0,15,0,0));
    vt.push_back(mk(0,0,1,1,0, 1,1,0,0, 0,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0));
    // overpayment for product 0 (price 10), two coins of change
    vt.push_back(mk(0,3,0,0,0, 0,0,0,0,10,0,0));
    vt.push_back(mk(0,3,0,0,0, 0,0,0,0,20,0,0));
    vt.push_back(mk(0,0,0,1,0, 1,0,0,0,10,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,1,0,10,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,1,0, 5,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0));
    // refund of 15
    vt.push_back(mk(0,3,0,0,0, 0,0,0,0,10,0,0));
    vt.push_back(mk(0,1,0,0,0, 0,0,0,0,15,0,0));
    vt.push_back(mk(0,0,0,0,1, 0,0,1,0,15,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,1,0,10,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,1,0, 5,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0));
    // invalid coin, overflow coin, coin during change
    vt.push_back(mk(0,2,0,0,0, 0,0,0,1, 0,0,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0));
    vt.push_back(mk(0,3,0,0,0, 0,0,0,0,10,0,0));
    vt.push_back(mk(0,3,0,0,0, 0,0,0,0,20,0,0));
    vt.push_back(mk(0,3,0,0,0, 0,0,0,0,30,0,0));
    vt.push_back(mk(0,3,0,0,0, 0,0,0,1,30,0,0));
    vt.push_back(mk(0,0,0,0,1, 0,0,1,0,30,1,0));
    vt.push_back(mk(0,1,0,0,0, 0,0,1,1,25,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,1,0,20,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,1,0,15,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,1,0,10,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,1,0, 5,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0));
    // three sales of product 0 empty its slot
    vt.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0));
    for (int k = 0; k < 3; k++) begin
      vt.push_back(mk(0,3,0,0,0, 0,0,0,0,10,0,0));
      vt.push_back(mk(0,0,0,1,0, 1,0,0,0, 0,1,(k == 2) ? 4'b0001 : 4'b0000));
      vt.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,(k == 2) ? 4'b0001 : 4'b0000));
    end
    vt.push_back(mk(0,3,0,0,0, 0,0,0,0,10,0,1));
    vt.push_back(mk(0,0,0,1,0, 0,0,0,0,10,0,1));
    vt.push_back(mk(0,0,0,0,1, 0,0,1,0,10,1,1));
    vt.push_back(mk(0,0,0,0,0, 0,0,1,0, 5,1,1));
    vt.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,1));
    // short credit, then buy with a simultaneous coin
    vt.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0));
    vt.push_back(mk(0,1,0,0,0, 0,0,0,0, 5,0,0));
    vt.push_back(mk(0,0,0,1,0, 0,0,0,0, 5,0,0));
    vt.push_back(mk(0,1,0,0,0, 0,0,0,0,10,0,0));
    vt.push_back(mk(0,1,0,1,0, 1,0,0,1, 0,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0));
    // reset in the middle of a refund
    vt.push_back(mk(0,3,0,0,0, 0,0,0,0,10,0,0));
    vt.push_back(mk(0,3,0,0,0, 0,0,0,0,20,0,0));
    vt.push_back(mk(0,3,0,0,0, 0,0,0,0,30,0,0));
    vt.push_back(mk(0,0,0,0,1, 0,0,1,0,30,1,0));
    vt.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0));

    foreach (vt[i]) begin
      tick(vt[i].r, vt[i].c, vt[i].s, vt[i].b, vt[i].x);
      chk($sformatf("row%0d vend", i), int'(vend), int'(vt[i].v));
      if (vt[i].v) chk($sformatf("row%0d vend_id", i), int'(vend_id), int'(vt[i].id));
      chk($sformatf("row%0d change_five", i), int'(change_five), int'(vt[i].ch));
      chk($sformatf("row%0d coin_reject", i), int'(coin_reject), int'(vt[i].rj));
      chk($sformatf("row%0d credit", i), int'(credit), int'(vt[i].cr));
      chk($sformatf("row%0d busy", i), int'(busy), int'(vt[i].bz));
      chk($sformatf("row%0d sold_out", i), int'(sold_out), int'(vt[i].so));
    end

    // Stock is full again after the mid-refund reset: only the third sale empties it.
    for (int k = 0; k < 3; k++) begin
      tick(0, 2'b11, 2'd0, 0, 0);
      tick(0, 2'b00, 2'd0, 1, 0);
      chk("restock vend", int'(vend), 1);
      chk("restock sold_out0", int'(sold_out[0]), (k == 2) ? 1 : 0);
      tick(0, 2'b00, 2'd0, 0, 0);
    end

    // Credit may reach exactly MAX_CREDIT but not beyond.
    tick(1, 2'b00, 2'd0, 0, 0);
    for (int k = 0; k < 3; k++) tick(0, 2'b11, 2'd0, 0, 0);
    tick(0, 2'b01, 2'd0, 0, 0);
    chk("max credit accept", int'(credit), 35);
    chk("max credit no reject", int'(coin_reject), 0);
    tick(0, 2'b01, 2'd0, 0, 0);
    chk("over max credit", int'(credit), 35);
    chk("over max reject", int'(coin_reject), 1);
    tick(0, 2'b00, 2'd3, 1, 0);
    chk("buy p3 vend_id", int'(vend_id), 3);
    chk("buy p3 credit", int'(credit), 10);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [1:0] c;
      r = int'($urandom_range(0, 9));
      c = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b11 : 2'b10;
      tick(($urandom_range(0, 199) == 0), c, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
